// File: rtl/i2c_seq_pkg.sv
// i2c_seq_pkg: shared types and constants for the I2C master sequencer.
//   state_t           - sequencer FSM states
//   *_DEF             - default bit-slot timing (clocks)
//   ACK / NACK        - SDA levels in the acknowledge slot
//   bitrev8           - byte bit reversal, used for MSB-first ordering
package i2c_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_ADDR,
    S_ADDR_ACK,
    S_WAIT_WR,
    S_WRITE,
    S_WRITE_ACK,
    S_READ,
    S_READ_ACK,
    S_STOP
  } state_t;

  localparam int unsigned LOW_CYCLES_DEF  = 5;
  localparam int unsigned HIGH_CYCLES_DEF = 5;
  localparam int unsigned SETUP_DEF       = 3;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  function automatic logic [7:0] bitrev8(input logic [7:0] v);
    logic [7:0] r;
    r = '0;
    for (int unsigned i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

endpackage

// File: rtl/i2c_bit_timer.sv
// i2c_bit_timer: bit-slot counter for the I2C master sequencer.
// A slot runs LOW_CYCLES clocks with SCL low, then HIGH_CYCLES with SCL high.
//   clock, reset   - system clock, async active-low reset
//   i_load         - load the counter instead of counting (holds while asserted)
//   i_load_hi      - load value: 1 = start of high phase, 0 = start of slot
//   o_scl          - registered SCL level
//   o_setup        - last cycle before the SDA update point
//   o_sample       - SDA sample cycle
//   o_pre_end      - second-to-last cycle of the slot
//   o_end          - last cycle of the slot
module i2c_bit_timer #(
  parameter int unsigned LOW_CYCLES  = 5,
  parameter int unsigned HIGH_CYCLES = 5,
  parameter int unsigned SETUP       = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic i_load,
  input  logic i_load_hi,
  output logic o_scl,
  output logic o_setup,
  output logic o_sample,
  output logic o_pre_end,
  output logic o_end
);

  localparam int unsigned SLOT = LOW_CYCLES + HIGH_CYCLES;
  localparam int unsigned CW   = $clog2(SLOT);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_nxt;
  logic          r_scl;

  always_comb begin
    w_nxt = r_cnt;
    if (i_load)
      w_nxt = i_load_hi ? CW'(LOW_CYCLES) : '0;
    else if (r_cnt == CW'(SLOT - 1))
      w_nxt = '0;
    else
      w_nxt = r_cnt + CW'(1);
  end

  // SCL is registered from the next count so it lines up with r_cnt.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt <= CW'(LOW_CYCLES);
      r_scl <= 1'b1;
    end else begin
      r_cnt <= w_nxt;
      r_scl <= (w_nxt >= CW'(LOW_CYCLES));
    end
  end

  // SDA is registered in the top, so the update is requested one cycle early.
  assign o_setup   = (r_cnt == CW'(SETUP - 1));
  assign o_sample  = (r_cnt == CW'(LOW_CYCLES + HIGH_CYCLES / 2));
  assign o_pre_end = (r_cnt == CW'(SLOT - 2));
  assign o_end     = (r_cnt == CW'(SLOT - 1));
  assign o_scl     = r_scl;

endmodule

// File: rtl/i2c_master_sequencer.sv
// i2c_master_sequencer: I2C bus master. Sequences START, address + R/W,
// ACK checks, data bytes and STOP for one request.
//   clock, reset          - system clock, async active-low reset
//   start/addr/rw/nbytes  - request (sampled in IDLE only)
//   wr_data/wr_valid      - write byte handshake (wr_ready out)
//   rd_data/rd_valid      - received byte and one-cycle strobe
//   busy/done/nack        - status
//   SCL/SDA_out/SDA_in    - bus pins (SDA_out 1 = release)
module i2c_master_sequencer
  import i2c_seq_pkg::*;
#(
  parameter int unsigned LOW_CYCLES  = LOW_CYCLES_DEF,
  parameter int unsigned HIGH_CYCLES = HIGH_CYCLES_DEF,
  parameter int unsigned SETUP       = SETUP_DEF,
  parameter int unsigned MSB_FIRST   = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic       rw,
  input  logic [3:0] nbytes,
  input  logic [7:0] wr_data,
  input  logic       wr_valid,
  output logic       wr_ready,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       busy,
  output logic       done,
  output logic       nack,
  output logic       SCL,
  output logic       SDA_out,
  input  logic       SDA_in
);

  state_t     r_state;
  logic       r_phase;
  logic [2:0] r_bit;
  logic [7:0] r_sh;
  logic [3:0] r_bytes;
  logic       r_rw;
  logic       r_ack;
  logic       r_sda;
  logic       r_busy;
  logic       r_done;
  logic       r_nack;
  logic       r_wr_ready;
  logic       r_rd_valid;
  logic [7:0] r_rd_data;

  logic w_load, w_load_hi;
  logic w_scl, w_setup, w_sample, w_pre_end, w_end;

  // Timer is parked at the high phase in IDLE and between START/STOP halves,
  // and held at slot start while stretching in WAIT_WR.
  assign w_load = (r_state == S_IDLE) || (r_state == S_WAIT_WR) ||
                  (w_end && ((r_state == S_STOP) ||
                             (r_state == S_START && !r_phase)));
  assign w_load_hi = (r_state != S_WAIT_WR);

  i2c_bit_timer #(
    .LOW_CYCLES (LOW_CYCLES),
    .HIGH_CYCLES(HIGH_CYCLES),
    .SETUP      (SETUP)
  ) u_timer (
    .clock    (clock),
    .reset    (reset),
    .i_load   (w_load),
    .i_load_hi(w_load_hi),
    .o_scl    (w_scl),
    .o_setup  (w_setup),
    .o_sample (w_sample),
    .o_pre_end(w_pre_end),
    .o_end    (w_end)
  );

  // Shift register always transmits bit 0; MSB-first order is handled at load.
  function automatic logic [7:0] tx_frame(input logic [7:0] b);
    return (MSB_FIRST != 0) ? bitrev8(b) : b;
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_phase    <= 1'b0;
      r_bit      <= '0;
      r_sh       <= '0;
      r_bytes    <= '0;
      r_rw       <= 1'b0;
      r_ack      <= NACK;
      r_sda      <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_nack     <= 1'b0;
      r_wr_ready <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_done     <= 1'b0;
      r_rd_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_sda <= 1'b1;
          if (start) begin
            r_sh    <= (MSB_FIRST != 0) ? bitrev8({addr, rw}) : {rw, addr};
            r_rw    <= rw;
            r_bytes <= nbytes;
            r_nack  <= 1'b0;
            r_busy  <= 1'b1;
            r_phase <= 1'b0;
            r_bit   <= '0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_end) begin
            if (!r_phase) begin
              r_phase <= 1'b1;
              r_sda   <= 1'b0;
            end else begin
              r_phase <= 1'b0;
              r_state <= S_ADDR;
            end
          end
        end
        S_ADDR, S_WRITE: begin
          if (w_setup) begin
            r_sda <= r_sh[0];
            r_sh  <= {1'b0, r_sh[7:1]};
          end
          if (w_end) begin
            if (r_bit == 3'd7) begin
              r_bit   <= '0;
              r_state <= (r_state == S_ADDR) ? S_ADDR_ACK : S_WRITE_ACK;
            end else begin
              r_bit <= r_bit + 3'd1;
            end
          end
        end
        S_ADDR_ACK, S_WRITE_ACK: begin
          if (w_setup)  r_sda <= NACK;
          if (w_sample) r_ack <= SDA_in;
          if (w_end) begin
            if (r_ack == NACK) begin
              r_nack  <= 1'b1;
              r_state <= S_STOP;
            end else if (r_state == S_ADDR_ACK) begin
              if (r_bytes == 4'd0) begin
                r_state <= S_STOP;
              end else if (r_rw) begin
                r_state <= S_READ;
              end else begin
                r_wr_ready <= 1'b1;
                r_state    <= S_WAIT_WR;
              end
            end else begin
              r_bytes <= r_bytes - 4'd1;
              if (r_bytes == 4'd1) begin
                r_state <= S_STOP;
              end else begin
                r_wr_ready <= 1'b1;
                r_state    <= S_WAIT_WR;
              end
            end
          end
        end
        S_WAIT_WR: begin
          if (wr_valid && r_wr_ready) begin
            r_sh       <= tx_frame(wr_data);
            r_wr_ready <= 1'b0;
            r_state    <= S_WRITE;
          end
        end
        S_READ: begin
          if (w_setup) r_sda <= NACK;
          if (w_sample) begin
            if (MSB_FIRST != 0) r_sh <= {r_sh[6:0], SDA_in};
            else                r_sh <= {SDA_in, r_sh[7:1]};
          end
          if (w_end) begin
            if (r_bit == 3'd7) begin
              r_bit      <= '0;
              r_rd_data  <= r_sh;
              r_rd_valid <= 1'b1;
              r_state    <= S_READ_ACK;
            end else begin
              r_bit <= r_bit + 3'd1;
            end
          end
        end
        S_READ_ACK: begin
          if (w_setup) r_sda <= (r_bytes == 4'd1) ? NACK : ACK;
          if (w_end) begin
            r_bytes <= r_bytes - 4'd1;
            r_state <= (r_bytes == 4'd1) ? S_STOP : S_READ;
          end
        end
        S_STOP: begin
          if (!r_phase) begin
            if (w_setup) r_sda <= 1'b0;
            if (w_end) begin
              r_phase <= 1'b1;
              r_sda   <= 1'b1;
            end
          end else begin
            if (w_pre_end) r_done <= 1'b1;
            if (w_end) begin
              r_phase <= 1'b0;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign SCL      = w_scl;
  assign SDA_out  = r_sda;
  assign busy     = r_busy;
  assign done     = r_done;
  assign nack     = r_nack;
  assign wr_ready = r_wr_ready;
  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;

endmodule
